// File: rtl/exc_pkg.sv
// Shared types and default sizing for the exception/interrupt capture unit.
// Pure declarations, no logic.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2
  } exc_state_t;

  localparam int DEF_NUM_SRC    = 8;
  localparam int DEF_CAUSE_W    = 5;
  localparam int DEF_PC_W       = 32;
  localparam int DEF_CAUSE_BASE = 0;

endpackage

// File: rtl/exc_prio_enc.sv
// Lowest-index-first priority encoder: valid flag, binary index and one-hot grant.
// Purely combinational, zero latency; no flow control.
module exc_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             vld,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     gnt
);

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld    = 1'b1;
        idx    = IDX_W'(i);
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_cause_unit.sv
// Exception capture: pending latch, lowest-index pick at an instruction boundary, cause/EPC record.
// Take pulse one cycle after the boundary decision; blocks further takes until eret.
module exc_cause_unit
  import exc_pkg::*;
#(
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int CAUSE_W    = DEF_CAUSE_W,
  parameter int PC_W       = DEF_PC_W,
  parameter int CAUSE_BASE = DEF_CAUSE_BASE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] exc_req,
  input  logic [NUM_SRC-1:0] exc_en,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               instr_boundary,
  input  logic               eret,
  output logic               exc_take,
  output logic [CAUSE_W-1:0] cause_o,
  output logic [PC_W-1:0]    epc_o,
  output logic               busy_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               lost_o
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  if (CAUSE_BASE + NUM_SRC - 1 >= 2 ** CAUSE_W) begin : g_cause_range_bad
    $error("exc_cause_unit: CAUSE_BASE+NUM_SRC-1 does not fit in CAUSE_W bits");
  end

  exc_state_t         state_q, state_d;
  logic [NUM_SRC-1:0] pending_q;
  logic               lost_q;
  logic [CAUSE_W-1:0] cause_q;
  logic [PC_W-1:0]    epc_q;

  logic [NUM_SRC-1:0] eligible;
  logic               enc_vld;
  logic [IDX_W-1:0]   enc_idx;
  logic [NUM_SRC-1:0] enc_gnt;
  logic               take_go;
  logic [NUM_SRC-1:0] clr;

  // Only the registered pending feeds selection, so a fresh request waits a cycle.
  assign eligible = pending_q & exc_en;

  exc_prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req (eligible),
    .vld (enc_vld),
    .idx (enc_idx),
    .gnt (enc_gnt)
  );

  always_comb begin
    state_d = state_q;
    take_go = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (instr_boundary && enc_vld) begin
          take_go = 1'b1;
          state_d = TAKE;
        end
      end
      TAKE:    state_d = HANDLER;
      HANDLER: if (eret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign clr = take_go ? enc_gnt : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      lost_q    <= 1'b0;
      cause_q   <= '0;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      // A new request on the granted bit re-arms it: set wins over clear.
      pending_q <= (pending_q & ~clr) | exc_req;
      if (|(exc_req & pending_q)) lost_q <= 1'b1;
      if (take_go) begin
        cause_q <= CAUSE_W'(CAUSE_BASE) + CAUSE_W'(enc_idx);
        epc_q   <= pc_i;
      end
    end
  end

  assign exc_take  = (state_q == TAKE);
  assign busy_o    = (state_q != IDLE);
  assign cause_o   = cause_q;
  assign epc_o     = epc_q;
  assign pending_o = pending_q;
  assign lost_o    = lost_q;

endmodule
